// File: rtl/resp_sig_checker.sv
// Response signature checker: folds each accepted DUT result word into a MISR
// and compares the final signature against a golden value after num_vec vectors.
module resp_sig_checker #(
  parameter int              DW   = 421,
  parameter int              SIGW = 32,
  parameter logic [SIGW-1:0] POLY = 32'h04C11DB7,
  parameter logic [SIGW-1:0] SEED = 32'hFFFFFFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      num_vec,
  input  logic            y_valid,
  input  logic [DW-1:0]   y,
  input  logic [SIGW-1:0] expected_sig,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [SIGW-1:0] signature,
  output logic [7:0]      vec_count
);

  localparam int NCHUNK = (DW + SIGW - 1) / SIGW;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t     state;
  logic [7:0] num_lat;

  // XOR of all SIGW-wide slices; the top slice is zero-extended past DW.
  function automatic logic [SIGW-1:0] fold(input logic [DW-1:0] v);
    logic [NCHUNK*SIGW-1:0] ext;
    logic [SIGW-1:0]        acc;
    ext          = '0;
    ext[DW-1:0]  = v;
    acc          = '0;
    for (int k = 0; k < NCHUNK; k++) acc ^= ext[SIGW*k +: SIGW];
    return acc;
  endfunction

  function automatic logic [SIGW-1:0] misr_step(input logic [SIGW-1:0] s,
                                                input logic [SIGW-1:0] f);
    logic [SIGW-1:0] fb;
    fb = s[SIGW-1] ? POLY : '0;
    return {s[SIGW-2:0], 1'b0} ^ fb ^ f;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      signature <= SEED;
      vec_count <= '0;
      num_lat   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // The start cycle only arms the run; y on this edge is never folded in.
          if (start) begin
            signature <= SEED;
            vec_count <= '0;
            num_lat   <= num_vec;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= (num_vec == 8'd0) ? CHECK : RUN;
          end
        end
        RUN: begin
          if (y_valid) begin
            signature <= misr_step(signature, fold(y));
            if (vec_count != 8'hFF) vec_count <= vec_count + 8'd1;
            if (vec_count + 8'd1 == num_lat) state <= CHECK;
          end
        end
        CHECK: begin
          pass  <= (signature == expected_sig);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resp_sig_checker.sv
// Scoreboard bench for resp_sig_checker: a bit-serial signature model queues
// expected results at stimulus time; they are popped when done rises.
module tb_resp_sig_checker;

  localparam int          DW   = 421;
  localparam int          SIGW = 32;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic            clk = 1'b0;
  logic            rst_n, start, y_valid;
  logic [7:0]      num_vec;
  logic [DW-1:0]   y;
  logic [SIGW-1:0] expected_sig;
  logic            busy, done, pass;
  logic [SIGW-1:0] signature;
  logic [7:0]      vec_count;

  always #5 clk = ~clk;

  resp_sig_checker #(.DW(DW), .SIGW(SIGW), .POLY(POLY), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .y_valid(y_valid), .y(y), .expected_sig(expected_sig),
    .busy(busy), .done(done), .pass(pass),
    .signature(signature), .vec_count(vec_count)
  );

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] msig;
  logic [7:0]  mcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: y bit i lands on signature bit i mod 32.
  function automatic logic [31:0] m_fold(input logic [DW-1:0] v);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < DW; i++) acc[i % 32] = acc[i % 32] ^ v[i];
    return acc;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [DW-1:0] v);
    logic [31:0] ns;
    ns = s << 1;
    if (s[31]) ns = ns ^ POLY;
    return ns ^ m_fold(v);
  endfunction

  function automatic logic [DW-1:0] rand_y();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i += 32) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] n, input logic yv);
    start   = 1'b1;
    num_vec = n;
    y_valid = yv;
    y       = rand_y();
    tick();
    start   = 1'b0;
    y_valid = 1'b0;
    msig    = SEED;
    mcnt    = 8'd0;
  endtask

  task automatic send(input logic v, input logic [DW-1:0] yy);
    y_valid = v;
    y       = yy;
    if (v) begin
      msig = m_step(msig, yy);
      mcnt = mcnt + 8'd1;
    end
    tick();
    y_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] esig);
    exp_t e;
    expected_sig = esig;
    e.sig  = msig;
    e.pass = (msig == esig);
    e.cnt  = mcnt;
    sbq.push_back(e);
  endtask

  // Called right after the last accept (or the start of an empty run):
  // the result must be visible exactly one further edge later.
  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    e = sbq.pop_front();
    if (!done) chk({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      chk({tag, "_lat"},  64'(n),         64'd1);
      chk({tag, "_sig"},  64'(signature), 64'(e.sig));
      chk({tag, "_pass"}, 64'(pass),      64'(e.pass));
      chk({tag, "_cnt"},  64'(vec_count), 64'(e.cnt));
      chk({tag, "_busy"}, 64'(busy),      64'd0);
    end
  endtask

  initial begin
    logic [DW-1:0] t;
    rst_n = 1'b0; start = 1'b0; y_valid = 1'b0; num_vec = '0; y = '0; expected_sig = '0;
    msig = SEED; mcnt = '0;
    tick(); tick();
    chk("rst_sig",  64'(signature), 64'(SEED));
    chk("rst_cnt",  64'(vec_count), 64'd0);
    chk("rst_busy", 64'(busy),      64'd0);
    chk("rst_done", 64'(done),      64'd0);
    chk("rst_pass", 64'(pass),      64'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a run
    start_run(8'd10, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b1, rand_y());
    chk("mid_cnt", 64'(vec_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_sig",  64'(signature), 64'(SEED));
    chk("arst_cnt",  64'(vec_count), 64'd0);
    chk("arst_busy", 64'(busy),      64'd0);
    chk("arst_done", 64'(done),      64'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Single zero vector against the known golden value
    start_run(8'd1, 1'b0);
    send(1'b1, '0);
    chk("y0_sig",  64'(signature), 64'h0FB3EE249);
    chk("y0_busy", 64'(busy),      64'd1);
    chk("y0_done", 64'(done),      64'd0);
    push_exp(32'hFB3EE249);
    wait_done("y0");
    chk("y0_pass_k", 64'(pass), 64'd1);

    // Fold aliasing and the zero-extended top chunk
    start_run(8'd1, 1'b0);
    send(1'b1, DW'(1));
    chk("y1_sig", 64'(signature), 64'h0FB3EE248);
    push_exp(32'h0);
    wait_done("y1");
    t = '0; t[32] = 1'b1;
    start_run(8'd1, 1'b0);
    send(1'b1, t);
    chk("b32_sig", 64'(signature), 64'h0FB3EE248);
    push_exp(32'h0);
    wait_done("b32");
    t = '0; t[420] = 1'b1;
    start_run(8'd1, 1'b0);
    send(1'b1, t);
    chk("b420_sig", 64'(signature), 64'h0FB3EE259);
    push_exp(32'h0);
    wait_done("b420");
    chk("b420_pass_k", 64'(pass), 64'd0);

    // Gaps in y_valid, with a stray start that RUN must ignore
    start_run(8'd3, 1'b0);
    send(1'b1, '0);
    chk("gap_c1", 64'(vec_count), 64'd1);
    start = 1'b1; num_vec = 8'd1;
    send(1'b0, rand_y());
    start = 1'b0;
    chk("gap_c2", 64'(vec_count), 64'd1);
    chk("gap_b2", 64'(busy),      64'd1);
    send(1'b0, rand_y());
    chk("gap_c3", 64'(vec_count), 64'd1);
    send(1'b1, '0);
    chk("gap_c4", 64'(vec_count), 64'd2);
    chk("gap_d4", 64'(done),      64'd0);
    send(1'b1, '0);
    chk("gap_c5", 64'(vec_count), 64'd3);
    chk("gap_b5", 64'(busy),      64'd1);
    chk("gap_d5", 64'(done),      64'd0);
    push_exp(32'h0);
    wait_done("gap");

    // Empty run goes straight to CHECK
    start_run(8'd0, 1'b0);
    chk("nv0_busy", 64'(busy), 64'd1);
    push_exp(32'hFFFFFFFF);
    wait_done("nv0");

    // Restart from DONE; y on the start cycle must not be folded
    start_run(8'd1, 1'b1);
    chk("rs_done", 64'(done),      64'd0);
    chk("rs_sig",  64'(signature), 64'(SEED));
    chk("rs_cnt",  64'(vec_count), 64'd0);
    send(1'b1, rand_y());
    push_exp(msig);
    wait_done("rs");

    // Random gapped run, a deliberate golden mismatch, and a full-length run
    start_run(8'd20, 1'b0);
    for (int i = 0; i < 200 && mcnt < 8'd20; i++) send(($urandom_range(0, 3) != 0), rand_y());
    push_exp(msig);
    wait_done("rnd");
    start_run(8'd5, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b1, rand_y());
    push_exp(msig ^ 32'h1);
    wait_done("bad");
    start_run(8'd255, 1'b0);
    for (int i = 0; i < 255; i++) send(1'b1, rand_y());
    push_exp(msig);
    wait_done("full");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
